// File: rtl/irq_source_ctrl.sv
// Source-side interrupt controller: edge capture, mask, fixed-priority
// arbitration and a one-hot request held until ack, blocked until eoi.
module irq_source_ctrl #(
   parameter int          NSRC     = 4,
   parameter int unsigned VEC_BASE = 124,
   parameter logic [3:0]  MASK_RST = 4'b1111
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src_done,
   input  logic            int_ack,
   input  logic            eoi,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wd,
   input  logic [NSRC-1:0] ovr_clr,
   output logic [NSRC-1:0] irq_out,
   output logic [31:0]     vec_addr,
   output logic [NSRC-1:0] pending,
   output logic [NSRC-1:0] mask,
   output logic [NSRC-1:0] overrun,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state, state_nx;
   logic [1:0]      grant, grant_nx;
   logic [NSRC-1:0] src_d, rise, ack_clr, elig;

   always_comb begin
      rise    = src_done & ~src_d;
      ack_clr = '0;
      if (state == REQ && int_ack)
         ack_clr[grant] = 1'b1;
      elig    = pending & mask;
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      unique case (state)
         IDLE: begin
            if (|elig) begin
               state_nx = REQ;
               // bit 0 has the highest priority
               priority case (1'b1)
                  elig[0]: grant_nx = 2'd0;
                  elig[1]: grant_nx = 2'd1;
                  elig[2]: grant_nx = 2'd2;
                  elig[3]: grant_nx = 2'd3;
                  default: grant_nx = grant;
               endcase
            end
         end
         REQ:     if (int_ack) state_nx = SERVICE;
         SERVICE: if (eoi) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      irq_out = '0;
      if (state == REQ)
         irq_out[grant] = 1'b1;
      busy = (state != IDLE);
      if (state == IDLE)
         vec_addr = '0;
      else
         vec_addr = {30'(VEC_BASE) + 30'(grant), 2'b00};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= '0;
         pending <= '0;
         overrun <= '0;
         mask    <= MASK_RST;
         src_d   <= src_done;
      end else begin
         state   <= state_nx;
         grant   <= grant_nx;
         src_d   <= src_done;
         // a rise on the acked bit re-arms it and is not an overrun
         pending <= (pending & ~ack_clr) | rise;
         overrun <= (overrun & ~ovr_clr) | (rise & pending & ~ack_clr);
         if (mask_we)
            mask <= mask_wd;
      end
   end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl with a per-cycle behavioural
// model and hand-computed spot checks.
module tb_irq_source_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  src_done, mask_wd, ovr_clr;
   logic        int_ack, eoi, mask_we;
   logic [3:0]  irq_out, pending, mask, overrun;
   logic [31:0] vec_addr;
   logic        busy;

   int errors = 0;
   int checks = 0;

   irq_source_ctrl dut (
      .clk(clk), .reset(reset), .src_done(src_done),
      .int_ack(int_ack), .eoi(eoi), .mask_we(mask_we),
      .mask_wd(mask_wd), .ovr_clr(ovr_clr), .irq_out(irq_out),
      .vec_addr(vec_addr), .pending(pending), .mask(mask),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: which source is being requested / serviced, if any
   bit [3:0] m_pend = 0, m_ovr = 0, m_mask = 4'hF, m_prev = 0;
   bit       m_req = 0, m_svc = 0;
   int       m_src = 0;

   always @(posedge clk) begin
      bit [3:0] r, clr, el;
      if (reset) begin
         m_pend = 0; m_ovr = 0; m_mask = 4'hF;
         m_req = 0; m_svc = 0; m_src = 0;
         m_prev = src_done;
      end else begin
         r = src_done & ~m_prev;
         m_prev = src_done;
         clr = 0;
         if (m_req && int_ack) clr[m_src] = 1;
         el = m_pend & m_mask;
         if (m_req) begin
            if (int_ack) begin m_req = 0; m_svc = 1; end
         end else if (m_svc) begin
            if (eoi) m_svc = 0;
         end else if (el != 0) begin
            for (int i = 3; i >= 0; i--)
               if (el[i]) m_src = i;
            m_req = 1;
         end
         m_ovr = (m_ovr & ~ovr_clr) | (r & m_pend & ~clr);
         m_pend = (m_pend & ~clr) | r;
         if (mask_we) m_mask = mask_wd;
      end
      #1;
      check("irq_out", {28'd0, irq_out}, m_req ? (32'd1 << m_src) : 32'd0);
      check("vec_addr", vec_addr,
            (m_req || m_svc) ? 32'((124 + m_src) * 4) : 32'd0);
      check("busy", {31'd0, busy}, {31'd0, (m_req || m_svc)});
      check("pending", {28'd0, pending}, {28'd0, m_pend});
      check("overrun", {28'd0, overrun}, {28'd0, m_ovr});
      check("mask", {28'd0, mask}, {28'd0, m_mask});
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack_pulse();
      int_ack = 1; tick(); int_ack = 0;
   endtask

   task automatic eoi_pulse();
      eoi = 1; tick(); eoi = 0;
   endtask

   initial begin
      reset = 1; src_done = 0; int_ack = 0; eoi = 0;
      mask_we = 0; mask_wd = 0; ovr_clr = 0;
      tick(2);
      reset = 0;
      check("rst_irq", {28'd0, irq_out}, 32'd0);
      check("rst_mask", {28'd0, mask}, 32'hF);

      // single request, stray eoi in REQ and int_ack in SERVICE ignored
      src_done = 4'b0001; tick();
      check("t1_pend", {28'd0, pending}, 32'h1);
      check("t1_irq0", {28'd0, irq_out}, 32'h0);
      tick();
      check("t1_irq", {28'd0, irq_out}, 32'h1);
      check("t1_vec", vec_addr, 32'h1F0);
      eoi_pulse();
      check("t1_hold", {28'd0, irq_out}, 32'h1);
      ack_pulse();
      check("t1_clr", {28'd0, pending}, 32'h0);
      check("t1_irqoff", {28'd0, irq_out}, 32'h0);
      ack_pulse();
      check("t1_busy", {31'd0, busy}, 32'h1);
      eoi_pulse();
      check("t1_idle", {31'd0, busy}, 32'h0);
      src_done = 0; tick();

      // priority
      src_done = 4'b1010; tick(2);
      check("t2_first", {28'd0, irq_out}, 32'h2);
      ack_pulse(); eoi_pulse();
      check("t2_gap", {28'd0, irq_out}, 32'h0);
      tick();
      check("t2_second", {28'd0, irq_out}, 32'h8);
      check("t2_vec", vec_addr, 32'h1FC);
      ack_pulse(); eoi_pulse();
      src_done = 0; tick();

      // mask
      mask_we = 1; mask_wd = 4'b1110; tick(); mask_we = 0;
      src_done = 4'b0001; tick(2);
      check("t3_pend", {28'd0, pending}, 32'h1);
      check("t3_masked", {28'd0, irq_out}, 32'h0);
      mask_we = 1; mask_wd = 4'b1111; tick(); mask_we = 0;
      tick();
      check("t3_unmask", {28'd0, irq_out}, 32'h1);
      ack_pulse(); eoi_pulse();
      src_done = 0; tick();

      // overrun and set-wins
      src_done = 4'b0100; tick();
      src_done = 0; tick();
      src_done = 4'b0100; tick();
      check("t4_ovr", {28'd0, overrun}, 32'h4);
      src_done = 0; ovr_clr = 4'b0100; tick(); ovr_clr = 0;
      check("t4_ovrclr", {28'd0, overrun}, 32'h0);
      src_done = 4'b0100; int_ack = 1; tick(); int_ack = 0;
      src_done = 0;
      check("t4_setwin", {28'd0, pending}, 32'h4);
      check("t4_noovr", {28'd0, overrun}, 32'h0);
      eoi_pulse(); tick();
      check("t4_rereq", {28'd0, irq_out}, 32'h4);
      ack_pulse(); eoi_pulse();

      // no retraction by a higher-priority edge
      src_done = 4'b0100; tick();
      src_done = 0; tick();
      src_done = 4'b0001; tick();
      check("t5_keep", {28'd0, irq_out}, 32'h4);
      check("t5_pend", {28'd0, pending}, 32'h5);
      tick();
      check("t5_keep2", {28'd0, irq_out}, 32'h4);
      src_done = 0;
      ack_pulse();
      check("t5_pend2", {28'd0, pending}, 32'h1);
      eoi_pulse(); tick();
      check("t5_next", {28'd0, irq_out}, 32'h1);
      ack_pulse();

      // reset mid-SERVICE with a level held through release
      mask_we = 1; mask_wd = 4'b0011; tick(); mask_we = 0;
      src_done = 4'b0010; reset = 1; tick(); reset = 0;
      check("t6_irq", {28'd0, irq_out}, 32'h0);
      check("t6_busy", {31'd0, busy}, 32'h0);
      check("t6_pend", {28'd0, pending}, 32'h0);
      check("t6_mask", {28'd0, mask}, 32'hF);
      tick(3);
      check("t6_nolvl", {28'd0, pending}, 32'h0);
      check("t6_noirq", {28'd0, irq_out}, 32'h0);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
